// File: rtl/spike_counter_pkg.sv
// Shared definitions for the spike counter: FSM state encoding and default widths.
package spike_counter_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned ID_W_DEF  = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StCount = 1'b1
    } state_e;

endpackage

// File: rtl/spike_counter.sv
// Windowed spike counter: counts (optionally id-filtered) spikes over back-to-back
// windows and hands each window's count to a valid/ready consumer.
module spike_counter
    import spike_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic             neuron_clk,
    input  logic             reset_sim_n,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [ID_W-1:0]  spkid_in,
    input  logic             filter_en,
    input  logic [ID_W-1:0]  filter_id,
    input  logic [31:0]      window_len,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    output logic [ID_W-1:0]  last_spkid,
    output logic             overrun,
    output logic             counting
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           r_state, w_state_next;
    logic [31:0]      r_timer, w_timer_next;
    logic [CNT_W-1:0] r_acc, w_acc_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_valid, w_valid_next;
    logic [ID_W-1:0]  r_last_id, w_last_id_next;
    logic             r_overrun, w_overrun_next;

    logic             w_hit;
    logic             w_win_end;
    logic [31:0]      w_win_last;
    logic [CNT_W-1:0] w_acc_inc;

    // window_len is compared live, so a mid-window change applies at the next compare.
    always_comb begin
        w_win_last = (window_len == 32'd0) ? 32'd0 : window_len - 32'd1;
        w_hit      = (r_state == StCount) && spike_in &&
                     (!filter_en || (spkid_in == filter_id));
        w_acc_inc  = (w_hit && (r_acc != CntMax)) ? r_acc + CNT_W'(1) : r_acc;
        w_win_end  = (r_state == StCount) && enable && (r_timer == w_win_last);
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_acc_next   = r_acc;
        case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_next = StCount;
                    w_timer_next = '0;
                    w_acc_next   = '0;
                end
            end
            StCount: begin
                if (!enable) begin
                    w_state_next = StIdle;
                    w_timer_next = '0;
                    w_acc_next   = '0;
                end else if (w_win_end) begin
                    w_timer_next = '0;
                    w_acc_next   = '0;
                end else begin
                    w_timer_next = r_timer + 32'd1;
                    w_acc_next   = w_acc_inc;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // A finished window loads only if the slot is free or being drained this cycle.
    always_comb begin
        w_cnt_next     = r_cnt;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;
        w_last_id_next = r_last_id;
        if (w_hit) begin
            w_last_id_next = spkid_in;
        end
        if (w_win_end) begin
            if (!r_valid || cnt_ready) begin
                w_cnt_next   = w_acc_inc;
                w_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end else if (r_valid && cnt_ready) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge neuron_clk) begin
        if (!reset_sim_n) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_last_id <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_valid   <= w_valid_next;
            r_last_id <= w_last_id_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign cnt_out    = r_cnt;
    assign cnt_valid  = r_valid;
    assign last_spkid = r_last_id;
    assign overrun    = r_overrun;
    assign counting   = (r_state == StCount);

endmodule

// File: tb/tb_spike_counter.sv
// Scoreboard bench for spike_counter; a second CNT_W=4 instance covers saturation.
module tb_spike_counter;

    logic        clk = 1'b0;
    logic        rst_n, enable, spike, filter_en, cnt_ready;
    logic [15:0] spkid, filter_id;
    logic [31:0] window_len;

    logic [15:0] cnt_out, last_spkid;
    logic        cnt_valid, overrun, counting;
    logic [3:0]  cnt4_out;
    logic [15:0] last4;
    logic        valid4, ovr4, counting4;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    int          sp_id[64];

    always #5 clk = ~clk;

    spike_counter dut (
        .neuron_clk (clk),       .reset_sim_n(rst_n),     .enable    (enable),
        .spike_in   (spike),     .spkid_in   (spkid),     .filter_en (filter_en),
        .filter_id  (filter_id), .window_len (window_len), .cnt_ready(cnt_ready),
        .cnt_out    (cnt_out),   .cnt_valid  (cnt_valid), .last_spkid(last_spkid),
        .overrun    (overrun),   .counting   (counting)
    );

    spike_counter #(.CNT_W(4), .ID_W(16)) dut4 (
        .neuron_clk (clk),       .reset_sim_n(rst_n),     .enable    (enable),
        .spike_in   (spike),     .spkid_in   (spkid),     .filter_en (filter_en),
        .filter_id  (filter_id), .window_len (window_len), .cnt_ready(cnt_ready),
        .cnt_out    (cnt4_out),  .cnt_valid  (valid4),    .last_spkid(last4),
        .overrun    (ovr4),      .counting   (counting4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Results are compared when the handshake is about to complete at the next edge.
    always @(negedge clk) begin
        if (rst_n && cnt_valid && cnt_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
            else check("sb_cnt", {16'd0, cnt_out}, sb_q.pop_front());
        end
    end

    task automatic cyc(input logic sp, input int id);
        spike = sp;
        spkid = 16'(id);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_spikes();
        for (int i = 0; i < 64; i++) sp_id[i] = -1;
    endtask

    function automatic logic [31:0] exp_count(input int len);
        logic [31:0] c = 0;
        for (int i = 0; i < len; i++)
            if (sp_id[i] >= 0 && (!filter_en || sp_id[i] == int'(filter_id)))
                if (c < 32'd65535) c++;
        return c;
    endfunction

    task automatic run_win(input int len);
        for (int k = 0; k < len; k++) cyc(sp_id[k] >= 0, (sp_id[k] >= 0) ? sp_id[k] : 0);
        spike = 1'b0;
    endtask

    task automatic start();
        enable = 1'b1;
        cyc(1'b0, 0);
    endtask

    task automatic stop();
        enable = 1'b0;
        cyc(1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; spike = 1'b0; spkid = '0;
        filter_en = 1'b0; filter_id = '0; window_len = 32'd10; cnt_ready = 1'b1;
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        check("rst_cnt_out", {16'd0, cnt_out}, 32'd0);
        check("rst_valid", {31'd0, cnt_valid}, 32'd0);
        check("rst_last_id", {16'd0, last_spkid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_counting", {31'd0, counting}, 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 0);

        // Basic window, three spikes, consumer always ready.
        clear_spikes();
        sp_id[2] = 1; sp_id[5] = 2; sp_id[7] = 3;
        sb_q.push_back(exp_count(10));
        start();
        check("s1_counting", {31'd0, counting}, 32'd1);
        run_win(10);
        check("s1_valid_on", {31'd0, cnt_valid}, 32'd1);
        check("s1_last_id", {16'd0, last_spkid}, 32'd3);
        stop();
        check("s1_valid_pulse", {31'd0, cnt_valid}, 32'd0);
        check("s1_idle", {31'd0, counting}, 32'd0);

        // Id filter.
        filter_en = 1'b1; filter_id = 16'd5; window_len = 32'd8;
        clear_spikes();
        sp_id[0] = 5; sp_id[2] = 7; sp_id[4] = 5; sp_id[7] = 5;
        sb_q.push_back(exp_count(8));
        start();
        run_win(8);
        check("s2_last_id", {16'd0, last_spkid}, 32'd5);
        stop();

        // Saturation: 20 spikes into a 4-bit counter.
        filter_en = 1'b0; window_len = 32'd24;
        clear_spikes();
        for (int i = 0; i < 20; i++) sp_id[i] = 9;
        sb_q.push_back(exp_count(24));
        start();
        run_win(24);
        check("s3_sat_cnt", {28'd0, cnt4_out}, 32'd15);
        check("s3_sat_valid", {31'd0, valid4}, 32'd1);
        check("s3_sat_last_id", {16'd0, last4}, 32'd9);
        stop();

        // window_len=0 gives one-cycle windows; load and consume coincide every cycle.
        window_len = 32'd0;
        start();
        for (int k = 0; k < 6; k++) begin
            logic sp;
            sp = (k == 0 || k == 1 || k == 3);
            sb_q.push_back({31'd0, sp});
            cyc(sp, 3);
            check("s_len0_valid", {31'd0, cnt_valid}, 32'd1);
        end
        spike = 1'b0;
        check("s_len0_no_overrun", {31'd0, overrun}, 32'd0);
        stop();

        // Overrun: consumer stalls across two back-to-back windows.
        cnt_ready = 1'b0; window_len = 32'd6;
        start();
        clear_spikes();
        sp_id[1] = 1; sp_id[3] = 1;
        sb_q.push_back(exp_count(6));
        run_win(6);
        check("s4_overrun_pre", {31'd0, overrun}, 32'd0);
        clear_spikes();
        sp_id[0] = 2; sp_id[1] = 2; sp_id[2] = 2; sp_id[4] = 2;
        run_win(6);
        check("s4_cnt_kept", {16'd0, cnt_out}, 32'd2);
        check("s4_overrun", {31'd0, overrun}, 32'd1);
        check("s4_valid_held", {31'd0, cnt_valid}, 32'd1);
        cnt_ready = 1'b1;
        stop();
        cyc(1'b0, 0);
        check("s4_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Spike on the window-end cycle belongs to the ending window.
        window_len = 32'd4;
        start();
        clear_spikes();
        sp_id[3] = 8;
        sb_q.push_back(exp_count(4));
        run_win(4);
        clear_spikes();
        sp_id[1] = 8;
        sb_q.push_back(exp_count(4));
        run_win(4);
        stop();

        // Reset mid-window with a pending result; enable held high to show priority.
        cnt_ready = 1'b0; window_len = 32'd3;
        start();
        clear_spikes();
        sp_id[0] = 1; sp_id[2] = 2;
        run_win(3);
        check("s6_pending", {31'd0, cnt_valid}, 32'd1);
        cyc(1'b1, 4);
        rst_n = 1'b0;
        cyc(1'b0, 0);
        check("s6_rst_cnt", {16'd0, cnt_out}, 32'd0);
        check("s6_rst_valid", {31'd0, cnt_valid}, 32'd0);
        check("s6_rst_last_id", {16'd0, last_spkid}, 32'd0);
        check("s6_rst_overrun", {31'd0, overrun}, 32'd0);
        check("s6_rst_counting", {31'd0, counting}, 32'd0);
        rst_n = 1'b1; enable = 1'b0; cnt_ready = 1'b1;
        cyc(1'b0, 0);

        // Dropping enable mid-window discards the partial count.
        window_len = 32'd4;
        start();
        clear_spikes();
        sp_id[1] = 6;
        sb_q.push_back(exp_count(4));
        run_win(4);
        cyc(1'b1, 6);
        cyc(1'b1, 6);
        spike = 1'b0;
        stop();
        check("s6_abort_idle", {31'd0, counting}, 32'd0);
        check("s6_abort_cnt_kept", {16'd0, cnt_out}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0);
        check("s6_abort_no_result", {31'd0, cnt_valid}, 32'd0);
        start();
        clear_spikes();
        sp_id[3] = 6;
        sb_q.push_back(exp_count(4));
        run_win(4);
        stop();
        cyc(1'b0, 0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
